// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the fetch PC sequencer.
// State encodings, widths and the default reset vector.
package pc_sequencer_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h4000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic            event_v;
    logic [PC_W-1:0] target;
  } redir_t;

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// Branch / jump / jump-register target generation and link address.
// Purely combinational; jr beats jump beats branch.
import pc_sequencer_pkg::*;

module pc_target_calc (
  input  logic [PC_W-1:0] ex_pc,
  input  logic [15:0]     ex_imm16,
  input  logic [25:0]     ex_index26,
  input  logic [PC_W-1:0] jr_target,
  input  logic            branch_valid,
  input  logic            take_branch,
  input  logic            jump_valid,
  input  logic            jr_valid,
  output redir_t          redir,
  output logic [PC_W-1:0] link_addr
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] jr_tgt;

  assign seq_pc    = ex_pc + 32'd4;
  assign link_addr = ex_pc + 32'd8;
  assign br_tgt    = seq_pc + {{14{ex_imm16[15]}}, ex_imm16, 2'b00};
  assign j_tgt     = (seq_pc & 32'hF000_0000)
                   | {4'b0000, ex_index26, 2'b00};
  assign jr_tgt    = jr_target & ~32'd3;

  // Overlapping valids are possible, so an ordered chain, not a unique case.
  always_comb begin
    redir.event_v = 1'b0;
    redir.target  = br_tgt;
    if (jr_valid) begin
      redir.event_v = 1'b1;
      redir.target  = jr_tgt;
    end else if (jump_valid) begin
      redir.event_v = 1'b1;
      redir.target  = j_tgt;
    end else if (branch_valid && take_branch) begin
      redir.event_v = 1'b1;
      redir.target  = br_tgt;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register, stall/redirect sequencing and delay-slot aware redirect.
// Define PC_SEQ_BRANCH_STATS_EN to build the branch statistics counters.
import pc_sequencer_pkg::*;

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        take_branch,
  input  logic        jump_valid,
  input  logic        jr_valid,
  input  logic [31:0] ex_pc,
  input  logic [15:0] ex_imm16,
  input  logic [25:0] ex_index26,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        redirect,
  output logic [31:0] link_addr,
  output logic [31:0] branch_taken_cnt,
  output logic [31:0] branch_total_cnt
);

  redir_t redir;

  pc_target_calc u_calc (
    .ex_pc        (ex_pc),
    .ex_imm16     (ex_imm16),
    .ex_index26   (ex_index26),
    .jr_target    (jr_target),
    .branch_valid (branch_valid),
    .take_branch  (take_branch),
    .jump_valid   (jump_valid),
    .jr_valid     (jr_valid),
    .redir        (redir),
    .link_addr    (link_addr)
  );

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            fv_q, fv_d;
  logic            redir_q, redir_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    fv_d    = fv_q;
    redir_d = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        fv_d    = 1'b1;
      end
      RUN: begin
        if (!stall) begin
          if (redir.event_v) begin
            pc_d    = redir.target;
            redir_d = 1'b1;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end else if (redir.event_v) begin
          pend_d  = redir.target;
          state_d = HOLD;
        end
      end
      // The frozen execute stage re-presents its instruction; ignore it.
      HOLD: begin
        if (!stall) begin
          pc_d    = pend_q;
          redir_d = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        fv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      fv_q    <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      fv_q    <= fv_d;
      redir_q <= redir_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fv_q;
  assign redirect    = redir_q;

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [31:0] tot_q, tot_d;
  logic [31:0] tkn_q, tkn_d;
  logic        cnt_en;

  assign cnt_en = (state_q == RUN) && !stall && branch_valid;

  always_comb begin
    tot_d = tot_q;
    tkn_d = tkn_q;
    if (cnt_en) begin
      tot_d = tot_q + 32'd1;
      if (take_branch) tkn_d = tkn_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tot_q <= '0;
      tkn_q <= '0;
    end else begin
      tot_q <= tot_d;
      tkn_q <= tkn_d;
    end
  end

  assign branch_total_cnt = tot_q;
  assign branch_taken_cnt = tkn_q;
`else
  assign branch_total_cnt = '0;
  assign branch_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, redirects, stalls, wrap, stats.
// Stats expectations follow PC_SEQ_BRANCH_STATS_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_valid;
  logic        take_branch;
  logic        jump_valid;
  logic        jr_valid;
  logic [31:0] ex_pc;
  logic [15:0] ex_imm16;
  logic [25:0] ex_index26;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        redirect;
  logic [31:0] link_addr;
  logic [31:0] branch_taken_cnt;
  logic [31:0] branch_total_cnt;

  int checks = 0;
  int passed = 0;

  pc_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_valid     (branch_valid),
    .take_branch      (take_branch),
    .jump_valid       (jump_valid),
    .jr_valid         (jr_valid),
    .ex_pc            (ex_pc),
    .ex_imm16         (ex_imm16),
    .ex_index26       (ex_index26),
    .jr_target        (jr_target),
    .pc               (pc),
    .fetch_valid      (fetch_valid),
    .redirect         (redirect),
    .link_addr        (link_addr),
    .branch_taken_cnt (branch_taken_cnt),
    .branch_total_cnt (branch_total_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall        = 1'b0;
    branch_valid = 1'b0;
    take_branch  = 1'b0;
    jump_valid   = 1'b0;
    jr_valid     = 1'b0;
    ex_pc        = 32'h0;
    ex_imm16     = 16'h0;
    ex_index26   = 26'h0;
    jr_target    = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    checks++;
    if (pc !== 32'h4000_0000 || fetch_valid !== 1'b0 || redirect !== 1'b0)
      $display("FAIL reset: pc=%h fv=%b rd=%b want 40000000/0/0",
               pc, fetch_valid, redirect);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h4000_0000 || fetch_valid !== 1'b1 || redirect !== 1'b0)
      $display("FAIL boot: pc=%h fv=%b rd=%b want 40000000/1/0",
               pc, fetch_valid, redirect);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h4000_0004 || redirect !== 1'b0)
      $display("FAIL seq1: pc=%h rd=%b want 40000004/0", pc, redirect);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h4000_0008 || redirect !== 1'b0)
      $display("FAIL seq2: pc=%h rd=%b want 40000008/0", pc, redirect);
    else passed++;
  endtask

  task automatic test_branch();
    ex_pc        = 32'h4000_0010;
    ex_imm16     = 16'hFFFC;
    branch_valid = 1'b1;
    take_branch  = 1'b1;
    #1;
    checks++;
    if (link_addr !== 32'h4000_0018)
      $display("FAIL link: got %h want 40000018", link_addr);
    else passed++;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 32'h4000_0004 || redirect !== 1'b1)
      $display("FAIL br_taken: pc=%h rd=%b want 40000004/1", pc, redirect);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h4000_0008 || redirect !== 1'b0)
      $display("FAIL br_pulse: pc=%h rd=%b want 40000008/0", pc, redirect);
    else passed++;
    ex_pc        = 32'h4000_0010;
    ex_imm16     = 16'hFFFC;
    branch_valid = 1'b1;
    take_branch  = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 32'h4000_000C || redirect !== 1'b0)
      $display("FAIL br_not: pc=%h rd=%b want 4000000c/0", pc, redirect);
    else passed++;
  endtask

  task automatic test_jump();
    ex_pc      = 32'h4000_0020;
    ex_index26 = 26'h000_0040;
    jump_valid = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 32'h4000_0100 || redirect !== 1'b1)
      $display("FAIL jump: pc=%h rd=%b want 40000100/1", pc, redirect);
    else passed++;
    jr_valid  = 1'b1;
    jr_target = 32'h0000_1237;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 32'h0000_1234 || redirect !== 1'b1)
      $display("FAIL jr: pc=%h rd=%b want 00001234/1", pc, redirect);
    else passed++;
  endtask

  task automatic test_stall_hold();
    logic [31:0] held;
    tick();
    held         = pc;
    stall        = 1'b1;
    ex_pc        = 32'h4000_0000;
    ex_imm16     = 16'h001F;
    branch_valid = 1'b1;
    take_branch  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pc !== held || redirect !== 1'b0)
        $display("FAIL hold%0d: pc=%h rd=%b want %h/0",
                 i, pc, redirect, held);
      else passed++;
    end
    idle_inputs();
    tick();
    checks++;
    if (pc !== 32'h4000_0080 || redirect !== 1'b1)
      $display("FAIL hold_rel: pc=%h rd=%b want 40000080/1", pc, redirect);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h4000_0084 || redirect !== 1'b0)
      $display("FAIL hold_after: pc=%h rd=%b want 40000084/0", pc, redirect);
    else passed++;
  endtask

  task automatic test_reset_in_hold();
    stall        = 1'b1;
    ex_pc        = 32'h4000_0000;
    ex_imm16     = 16'h001F;
    branch_valid = 1'b1;
    take_branch  = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h4000_0000 || fetch_valid !== 1'b0 || redirect !== 1'b0)
      $display("FAIL rst_hold: pc=%h fv=%b rd=%b want 40000000/0/0",
               pc, fetch_valid, redirect);
    else passed++;
    idle_inputs();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h4000_0000 || redirect !== 1'b0 || fetch_valid !== 1'b1)
      $display("FAIL rst_boot: pc=%h rd=%b fv=%b want 40000000/0/1",
               pc, redirect, fetch_valid);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h4000_0004 || redirect !== 1'b0)
      $display("FAIL rst_nopend: pc=%h rd=%b want 40000004/0", pc, redirect);
    else passed++;
  endtask

  task automatic test_wrap_priority();
    jr_valid  = 1'b1;
    jr_target = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 32'hFFFF_FFFC)
      $display("FAIL wrap_set: pc=%h want fffffffc", pc);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h0000_0000 || redirect !== 1'b0)
      $display("FAIL wrap: pc=%h rd=%b want 00000000/0", pc, redirect);
    else passed++;
    jr_valid     = 1'b1;
    jr_target    = 32'h0000_2000;
    branch_valid = 1'b1;
    take_branch  = 1'b1;
    ex_pc        = 32'h4000_0000;
    ex_imm16     = 16'h0001;
    tick();
    idle_inputs();
    checks++;
    if (pc !== 32'h0000_2000 || redirect !== 1'b1)
      $display("FAIL prio: pc=%h rd=%b want 00002000/1", pc, redirect);
    else passed++;
  endtask

  task automatic test_stats();
    logic [4:0] taken;
    logic [4:0] stl;
    logic [31:0] exp_tot;
    logic [31:0] exp_tkn;
    taken = 5'b10101;
    stl   = 5'b10000;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      ex_pc        = 32'h4000_0000;
      ex_imm16     = 16'h0010;
      branch_valid = 1'b1;
      take_branch  = taken[i];
      stall        = stl[i];
      tick();
    end
    idle_inputs();
    tick();
`ifdef PC_SEQ_BRANCH_STATS_EN
    exp_tot = 32'd4;
    exp_tkn = 32'd2;
`else
    exp_tot = 32'd0;
    exp_tkn = 32'd0;
`endif
    checks++;
    if (branch_total_cnt !== exp_tot)
      $display("FAIL stat_total: got %0d want %0d",
               branch_total_cnt, exp_tot);
    else passed++;
    checks++;
    if (branch_taken_cnt !== exp_tkn)
      $display("FAIL stat_taken: got %0d want %0d",
               branch_taken_cnt, exp_tkn);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_stall_hold();
    test_reset_in_hold();
    test_wrap_priority();
    test_stats();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
